clk_div_prog: RTL and testbench

Parametrised, runtime-programmable clock-enable/clock divider; the next generation of the fixed 1 ms divider.
- Produces a divided square wave with programmable period and high time, plus a one-cycle period tick.
- New ratio and duty values are applied glitch-free at period boundaries, or immediately on a sync restart.
- Sits between the system clock domain and the slow-rate consumers (HDB3 bit timing, scan and display logic). All outputs are synchronous to i_clk.

---
 rtl/clk_div_prog.sv | 132 +++++++++++++
 tb/tb_clk_div_prog.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: registered divided clock, period tick,
// and glitch-free ratio/duty updates applied at period wrap or sync restart.
module clk_div_prog #(
  parameter int CNT_W       = 17,
  parameter int DIV_DEFAULT = 50000,
  parameter int HI_DEFAULT  = 25000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_hi,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_ack,
  output logic             o_err,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_a_q, div_a_d, hi_a_q, hi_a_d;
  logic [CNT_W-1:0] div_p_q, div_p_d, hi_p_q, hi_p_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic             load_ok;
  logic             wrap;
  logic [CNT_W-1:0] hi_c;

  // Clamp keeps both phases at least one cycle long for any accepted divisor.
  always_comb begin
    if (i_hi == '0)        hi_c = ONE;
    else if (i_hi >= i_div) hi_c = i_div - ONE;
    else                    hi_c = i_hi;
  end

  assign load_ok = i_load && (i_div >= TWO);
  assign wrap    = (cnt_q == div_a_q - ONE);

  always_comb begin
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    hi_a_d  = hi_a_q;
    div_p_d = div_p_q;
    hi_p_d  = hi_p_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    ack_d   = 1'b0;
    err_d   = i_load && !load_ok;

    if (i_sync) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (load_ok) begin
        div_a_d = i_div;
        hi_a_d  = hi_c;
        pend_d  = 1'b0;
        ack_d   = 1'b1;
      end else if (pend_q) begin
        div_a_d = div_p_q;
        hi_a_d  = hi_p_q;
        pend_d  = 1'b0;
        ack_d   = 1'b1;
      end
    end else begin
      if (i_en) begin
        if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          if (pend_q) begin
            div_a_d = div_p_q;
            hi_a_d  = hi_p_q;
            pend_d  = 1'b0;
            ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      // A load on a wrap edge lands in the shadow after the old one is consumed.
      if (load_ok) begin
        div_p_d = i_div;
        hi_p_d  = hi_c;
        pend_d  = 1'b1;
      end
    end

    // Derived from next-state values so o_clk stays aligned with o_cnt.
    clk_d = (cnt_d >= (div_a_d - hi_a_d));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      div_a_q <= CNT_W'(DIV_DEFAULT);
      hi_a_q  <= CNT_W'(HI_DEFAULT);
      div_p_q <= '0;
      hi_p_q  <= '0;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      hi_a_q  <= hi_a_d;
      div_p_q <= div_p_d;
      hi_p_q  <= hi_p_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign o_clk  = clk_q;
  assign o_tick = tick_q;
  assign o_ack  = ack_q;
  assign o_err  = err_q;
  assign o_cnt  = cnt_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: default ratio, loads, clamping, enable hold,
// sync restart and reset priority.
module tb_clk_div_prog;

  logic        i_clk, i_rst, i_en, i_sync, i_load;
  logic [16:0] i_div, i_hi;
  logic        o_clk, o_tick, o_ack, o_err;
  logic [16:0] o_cnt;

  int checks = 0;
  int errors = 0;
  int bad    = 0;

  clk_div_prog #(.CNT_W(17), .DIV_DEFAULT(50000), .HI_DEFAULT(25000)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (i_en),
    .i_sync(i_sync),
    .i_load(i_load),
    .i_div (i_div),
    .i_hi  (i_hi),
    .o_clk (o_clk),
    .o_tick(o_tick),
    .o_ack (o_ack),
    .o_err (o_err),
    .o_cnt (o_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expects cnt==0 at entry; walks one full period and returns at the next cnt==0.
  task automatic chk_period(input string tag, input int div, input int hi);
    for (int k = 0; k < div; k++) begin
      chk({tag, "_cnt"}, 32'(o_cnt), 32'(k));
      chk({tag, "_clk"}, 32'(o_clk), 32'(k >= div - hi));
      chk({tag, "_tick"}, 32'(o_tick), 32'(k == 0));
      if (k > 0) chk({tag, "_ack"}, 32'(o_ack), 32'(0));
      step(1);
    end
  endtask

  task automatic load(input int div, input int hi);
    i_load = 1'b1;
    i_div  = 17'(div);
    i_hi   = 17'(hi);
    step(1);
    i_load = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_sync = 1'b0; i_load = 1'b0; i_div = '0; i_hi = '0;
    step(2);
    i_rst = 1'b0;
    chk("rst_cnt", 32'(o_cnt), 0);
    chk("rst_clk", 32'(o_clk), 0);
    chk("rst_tick", 32'(o_tick), 0);
    chk("rst_ack", 32'(o_ack), 0);
    chk("rst_err", 32'(o_err), 0);

    // Default 25000 low / 25000 high, with a pending load taken at cnt=100.
    i_en = 1'b1;
    step(100);
    chk("t1_cnt100", 32'(o_cnt), 100);
    load(5, 2);
    chk("t2_noack", 32'(o_ack), 0);
    for (int e = 102; e <= 49999; e++) begin
      step(1);
      if (o_cnt !== 17'(e) || o_clk !== 1'(e >= 25000) || o_tick !== 1'b0 || o_ack !== 1'b0) bad++;
      if (e == 24999) chk("t1_clk_lo_end", 32'(o_clk), 0);
      if (e == 25000) chk("t1_clk_hi_start", 32'(o_clk), 1);
    end
    chk("t1_shape", 32'(bad), 0);
    step(1);
    chk("t1_wrap_cnt", 32'(o_cnt), 0);
    chk("t1_wrap_clk", 32'(o_clk), 0);
    chk("t1_wrap_tick", 32'(o_tick), 1);
    chk("t2_ack", 32'(o_ack), 1);
    chk_period("t2_p5", 5, 2);

    // Rejected load: error pulse, period stays 5.
    load(1, 0);
    chk("t3a_err", 32'(o_err), 1);
    chk("t3a_cnt", 32'(o_cnt), 1);
    step(4);
    chk("t3a_err_clr", 32'(o_err), 0);
    chk("t3a_noack", 32'(o_ack), 0);
    chk_period("t3a_p5", 5, 2);

    // hi >= div clamps to div-1.
    load(4, 9);
    step(4);
    chk("t3b_ack", 32'(o_ack), 1);
    chk_period("t3b_p4", 4, 3);

    // Two loads before one wrap: last wins, single ack.
    load(6, 3);
    load(8, 4);
    chk("t4_noack_early", 32'(o_ack), 0);
    step(2);
    chk("t4_ack", 32'(o_ack), 1);
    chk_period("t4_p8", 8, 4);

    // Enable low holds counter and o_clk, suppresses ticks.
    step(3);
    i_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (o_cnt !== 17'd3 || o_clk !== 1'b0 || o_tick !== 1'b0) bad++;
    end
    chk("t5_hold", 32'(bad), 0);
    i_en = 1'b1;
    step(1);
    chk("t5_resume_cnt", 32'(o_cnt), 4);
    chk("t5_resume_clk", 32'(o_clk), 1);
    step(4);
    chk("t5_wrap_tick", 32'(o_tick), 1);

    // hi==0 becomes 1.
    load(3, 0);
    step(7);
    chk("t3c_ack", 32'(o_ack), 1);
    chk_period("t3c_p3", 3, 1);

    // div=2 toggles every cycle.
    load(2, 1);
    step(2);
    chk("t3d_ack", 32'(o_ack), 1);
    chk_period("t3d_p2a", 2, 1);
    chk_period("t3d_p2b", 2, 1);

    // Pending value applied immediately by sync.
    load(7, 3);
    i_sync = 1'b1;
    step(1);
    i_sync = 1'b0;
    chk("t6_sync_ack", 32'(o_ack), 1);
    chk_period("t6_p7", 7, 3);

    // Sync with simultaneous load applies clamped value at once.
    step(2);
    i_sync = 1'b1;
    load(3, 5);
    i_sync = 1'b0;
    chk("t6_syncld_ack", 32'(o_ack), 1);
    chk_period("t6_p3", 3, 2);

    // Reset beats sync; defaults return.
    step(1);
    i_rst = 1'b1; i_sync = 1'b1;
    step(1);
    i_rst = 1'b0; i_sync = 1'b0;
    chk("t6_rst_cnt", 32'(o_cnt), 0);
    chk("t6_rst_tick", 32'(o_tick), 0);
    chk("t6_rst_ack", 32'(o_ack), 0);
    chk("t6_rst_clk", 32'(o_clk), 0);
    step(24999);
    chk("t6_def_lo", 32'(o_clk), 0);
    step(1);
    chk("t6_def_cnt", 32'(o_cnt), 25000);
    chk("t6_def_hi", 32'(o_clk), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
